// File: rtl/csr_irq_unit.sv
// ============================================================================
// csr_irq_unit: machine-mode timer interrupt controller and CSR subset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csr_irq_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_interrupt,
  input  logic        instr_valid,
  input  logic [31:0] pc_in,
  input  logic        is_mret,
  input  logic        csr_reg_rd,
  input  logic        csr_reg_wr,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        epc_taken,
  output logic [31:0] epc_evec
);

  localparam logic [11:0] C_ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] C_ADDR_MIE     = 12'h304;
  localparam logic [11:0] C_ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] C_ADDR_MEPC    = 12'h341;
  localparam logic [11:0] C_ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] C_ADDR_MIP     = 12'h344;
  localparam logic [31:0] C_CAUSE_MTI    = 32'h8000_0007;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_mtie_q, mie_mtie_d;
  logic        mip_mtip_q, mip_mtip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        epc_taken_q, epc_taken_d;
  logic [31:0] epc_evec_q, epc_evec_d;

  logic        irq_take;
  logic        mret_go;
  logic        wr_en;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic [31:0] trap_vec;

  always_comb begin
    old_val = 32'h0;
    case (csr_addr)
      C_ADDR_MSTATUS: old_val = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
      C_ADDR_MIE:     old_val = {24'h0, mie_mtie_q, 7'h00};
      C_ADDR_MTVEC:   old_val = mtvec_q;
      C_ADDR_MEPC:    old_val = mepc_q;
      C_ADDR_MCAUSE:  old_val = mcause_q;
      C_ADDR_MIP:     old_val = {24'h0, mip_mtip_q, 7'h00};
      default:        old_val = 32'h0;
    endcase
  end

  assign csr_rdata = csr_reg_rd ? old_val : 32'h0;

  always_comb begin
    new_val = old_val;
    case (csr_op)
      2'b01:   new_val = csr_wdata;
      2'b10:   new_val = old_val | csr_wdata;
      2'b11:   new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  assign irq_take = mip_mtip_q & mie_mtie_q & mstatus_mie_q & instr_valid & (state_q == ST_RUN);
  assign mret_go  = is_mret & instr_valid & ~irq_take & (state_q == ST_RUN);
  // An interrupted instruction re-executes later, so its CSR write must not land now.
  assign wr_en    = csr_reg_wr & (csr_op != 2'b00) & (state_q == ST_RUN) & ~irq_take;

  assign trap_vec = (mtvec_q[1:0] == 2'b01) ? ({mtvec_q[31:2], 2'b00} + 32'd28)
                                            : {mtvec_q[31:2], 2'b00};

  always_comb begin
    state_d        = ST_RUN;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_mtie_d     = mie_mtie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mip_mtip_d     = mip_mtip_q;
    epc_taken_d    = 1'b0;
    epc_evec_d     = 32'h0;

    if (wr_en) begin
      case (csr_addr)
        C_ADDR_MSTATUS: begin
          mstatus_mie_d  = new_val[3];
          mstatus_mpie_d = new_val[7];
        end
        C_ADDR_MIE:    mie_mtie_d = new_val[7];
        C_ADDR_MTVEC:  mtvec_d    = new_val[1] ? {new_val[31:2], 2'b00} : new_val;
        C_ADDR_MEPC:   mepc_d     = new_val & ~32'h3;
        C_ADDR_MCAUSE: mcause_d   = new_val;
        default: ;
      endcase
    end

    if (irq_take) begin
      state_d        = ST_TRAP;
      mepc_d         = pc_in & ~32'h3;
      mcause_d       = C_CAUSE_MTI;
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mip_mtip_d     = 1'b0;
      epc_taken_d    = 1'b1;
      epc_evec_d     = trap_vec;
    end else if (mret_go) begin
      state_d        = ST_RET;
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      epc_taken_d    = 1'b1;
      epc_evec_d     = mepc_q;
    end

    // A new pulse must not be lost when it coincides with the take.
    if (timer_interrupt) begin
      mip_mtip_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mip_mtip_q     <= 1'b0;
      mtvec_q        <= RESET_MTVEC;
      mepc_q         <= 32'h0;
      mcause_q       <= 32'h0;
      epc_taken_q    <= 1'b0;
      epc_evec_q     <= 32'h0;
    end else begin
      state_q        <= state_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_mtie_q     <= mie_mtie_d;
      mip_mtip_q     <= mip_mtip_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      epc_taken_q    <= epc_taken_d;
      epc_evec_q     <= epc_evec_d;
    end
  end

  assign epc_taken = epc_taken_q;
  assign epc_evec  = epc_evec_q;

endmodule

`default_nettype wire

// File: tb/tb_csr_irq_unit.sv
// ============================================================================
// tb_csr_irq_unit: directed self-checking bench for csr_irq_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csr_irq_unit;

  logic        clk;
  logic        rst;
  logic        timer_interrupt;
  logic        instr_valid;
  logic [31:0] pc_in;
  logic        is_mret;
  logic        csr_reg_rd;
  logic        csr_reg_wr;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc_evec;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MIP     = 12'h344;

  csr_irq_unit #(.RESET_MTVEC(32'h0000_0100)) dut (
    .clk             (clk),
    .rst             (rst),
    .timer_interrupt (timer_interrupt),
    .instr_valid     (instr_valid),
    .pc_in           (pc_in),
    .is_mret         (is_mret),
    .csr_reg_rd      (csr_reg_rd),
    .csr_reg_wr      (csr_reg_wr),
    .csr_addr        (csr_addr),
    .csr_op          (csr_op),
    .csr_wdata       (csr_wdata),
    .csr_rdata       (csr_rdata),
    .epc_taken       (epc_taken),
    .epc_evec        (epc_evec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr   = addr;
    csr_reg_rd = 1'b1;
    #1;
    chk(tag, csr_rdata, exp);
    csr_reg_rd = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
    csr_addr   = addr;
    csr_op     = op;
    csr_wdata  = data;
    csr_reg_wr = 1'b1;
    step();
    csr_reg_wr = 1'b0;
    csr_op     = 2'b00;
  endtask

  task automatic pulse();
    timer_interrupt = 1'b1;
    step();
    timer_interrupt = 1'b0;
  endtask

  initial begin
    rst = 1'b0; timer_interrupt = 1'b0; instr_valid = 1'b0; pc_in = 32'h0;
    is_mret = 1'b0; csr_reg_rd = 1'b0; csr_reg_wr = 1'b0; csr_addr = 12'h0;
    csr_op = 2'b00; csr_wdata = 32'h0;

    step(); step();
    chk("rst_taken", {31'h0, epc_taken}, 32'h0);
    chk("rst_evec", epc_evec, 32'h0);
    rd_chk("rst_mstatus", A_MSTATUS, 32'h0);
    rd_chk("rst_mie", A_MIE, 32'h0);
    rd_chk("rst_mtvec", A_MTVEC, 32'h100);
    rd_chk("rst_mepc", A_MEPC, 32'h0);
    rd_chk("rst_mcause", A_MCAUSE, 32'h0);
    rd_chk("rst_mip", A_MIP, 32'h0);
    rst = 1'b1;
    step();

    // Direct trap
    csr_wr(A_MTVEC, 2'b01, 32'h200);
    csr_wr(A_MIE, 2'b01, 32'h80);
    csr_wr(A_MSTATUS, 2'b10, 32'h8);
    rd_chk("setup_mstatus", A_MSTATUS, 32'h8);
    instr_valid = 1'b1;
    pc_in       = 32'h40;
    pulse();
    chk("dir_latency_e1", {31'h0, epc_taken}, 32'h0);
    step();
    chk("dir_taken", {31'h0, epc_taken}, 32'h1);
    chk("dir_evec", epc_evec, 32'h200);
    rd_chk("dir_mepc", A_MEPC, 32'h40);
    rd_chk("dir_mcause", A_MCAUSE, 32'h8000_0007);
    rd_chk("dir_mstatus", A_MSTATUS, 32'h80);
    rd_chk("dir_mip", A_MIP, 32'h0);
    step();
    chk("dir_one_cycle", {31'h0, epc_taken}, 32'h0);

    // Return
    is_mret = 1'b1;
    step();
    is_mret = 1'b0;
    chk("ret_taken", {31'h0, epc_taken}, 32'h1);
    chk("ret_evec", epc_evec, 32'h40);
    rd_chk("ret_mstatus", A_MSTATUS, 32'h88);
    step();
    chk("ret_one_cycle", {31'h0, epc_taken}, 32'h0);

    // Vectored trap with colliding pulse and CSR write in the take cycle
    csr_wr(A_MTVEC, 2'b01, 32'h201);
    rd_chk("vec_mtvec", A_MTVEC, 32'h201);
    pulse();
    timer_interrupt = 1'b1;
    csr_addr = A_MTVEC; csr_op = 2'b01; csr_wdata = 32'h300; csr_reg_wr = 1'b1;
    step();
    timer_interrupt = 1'b0; csr_reg_wr = 1'b0; csr_op = 2'b00;
    chk("vec_taken", {31'h0, epc_taken}, 32'h1);
    chk("vec_evec", epc_evec, 32'h21C);
    rd_chk("col_mip_set_wins", A_MIP, 32'h80);
    rd_chk("col_mtvec_kept", A_MTVEC, 32'h201);

    // Masked pending
    step();
    chk("mask_no_redirect", {31'h0, epc_taken}, 32'h0);
    csr_wr(A_MIP, 2'b11, 32'h80);
    rd_chk("mip_readonly", A_MIP, 32'h80);
    chk("mask_still_none", {31'h0, epc_taken}, 32'h0);
    pc_in = 32'h80;
    csr_wr(A_MSTATUS, 2'b10, 32'h8);
    chk("enable_next_cycle", {31'h0, epc_taken}, 32'h0);
    step();
    chk("pend_taken", {31'h0, epc_taken}, 32'h1);
    chk("pend_evec", epc_evec, 32'h21C);
    rd_chk("pend_mepc", A_MEPC, 32'h80);
    rd_chk("pend_mip_clr", A_MIP, 32'h0);
    step();

    // Field legalisation and unimplemented address
    csr_wr(A_MTVEC, 2'b01, 32'h303);
    rd_chk("mtvec_mode_1x", A_MTVEC, 32'h300);
    csr_wr(A_MEPC, 2'b01, 32'h123);
    rd_chk("mepc_align", A_MEPC, 32'h120);
    csr_wr(12'h345, 2'b01, 32'hFFFF_FFFF);
    rd_chk("unimpl_read", 12'h345, 32'h0);
    csr_wr(A_MSTATUS, 2'b01, 32'hFFFF_FFFF);
    rd_chk("mstatus_mask", A_MSTATUS, 32'h88);

    // Reset while the redirect strobe is active
    pulse();
    step();
    chk("pre_rst_taken", {31'h0, epc_taken}, 32'h1);
    rst = 1'b0;
    step();
    chk("midrst_taken", {31'h0, epc_taken}, 32'h0);
    chk("midrst_evec", epc_evec, 32'h0);
    rd_chk("midrst_mtvec", A_MTVEC, 32'h100);
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
